// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY wait states, one-cycle response pulse.
// Optional sub-word (byte/half) access with lane merge and sign extension is enabled by `DMEM_BYTE_ACCESS_EN.
`timescale 1ns/1ps

module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  LAT_CNT    = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [3:0]         r_cnt;

   logic               r_we;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
`ifdef DMEM_BYTE_ACCESS_EN
   logic [1:0]         r_size;
   logic               r_signed;
   logic [31:0]        w_shifted;
`endif

   logic               r_rsp_valid;
   logic [31:0]        r_rsp_rdata;
   logic               r_rsp_error;
   logic [31:0]        r_mem [DEPTH_WORDS];

   logic               w_req_ready;
   logic               w_accept;
   logic               w_access;
   logic [31:0]        w_offset;
   logic               w_out_of_range;
   logic [IDX_W-1:0]   w_idx;
   logic [1:0]         w_lane;
   logic [31:0]        w_word;
   logic [31:0]        w_load_data;
   logic [31:0]        w_wmask;
   logic [31:0]        w_wbits;
   logic               w_error;
   logic               w_mem_we;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)      w_next_state = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0)  w_next_state = S_RESP;
         S_RESP:                      w_next_state = S_IDLE;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM: output decode ----------------
   always_comb begin
      w_req_ready = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         S_IDLE:  w_req_ready = 1'b1;
         S_WAIT:  w_access    = (r_cnt == 4'd0);
         default: ;
      endcase
   end

   assign w_accept  = w_req_ready & req_valid;
   assign req_ready = w_req_ready;

   always_ff @(posedge clock) begin
      if (reset)                                   r_cnt <= 4'd0;
      else if (w_accept)                           r_cnt <= LAT_CNT;
      else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
   end

   // NOTE: holding registers are pure datapath qualified by the FSM, so they carry no reset.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_we     <= req_we;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
`ifdef DMEM_BYTE_ACCESS_EN
         r_size   <= req_size;
         r_signed <= req_signed;
`endif
      end
   end

   // Decode works only from the captured request; live inputs never reach the access.
   assign w_offset       = r_addr - BASE_ADDR;
   assign w_out_of_range = (w_offset >= SPAN_BYTES);
   assign w_idx          = w_offset[IDX_W+1:2];
   assign w_lane         = w_offset[1:0];
   assign w_word         = r_mem[w_idx];

`ifdef DMEM_BYTE_ACCESS_EN
   // Big-endian: shifting left by lane*8 brings the addressed lane to the top byte.
   assign w_shifted = w_word << {w_lane, 3'b000};

   always_comb begin
      w_error     = w_out_of_range;
      w_wmask     = 32'h0;
      w_wbits     = 32'h0;
      w_load_data = 32'h0;
      case (r_size)
         2'b00: begin
            w_wmask     = 32'hFF00_0000 >> {w_lane, 3'b000};
            w_wbits     = {r_wdata[7:0], 24'h0} >> {w_lane, 3'b000};
            w_load_data = {{24{r_signed & w_shifted[31]}}, w_shifted[31:24]};
         end
         2'b01: begin
            if (w_lane[0]) w_error = 1'b1;
            w_wmask     = 32'hFFFF_0000 >> {w_lane, 3'b000};
            w_wbits     = {r_wdata[15:0], 16'h0} >> {w_lane, 3'b000};
            w_load_data = {{16{r_signed & w_shifted[31]}}, w_shifted[31:16]};
         end
         2'b10: begin
            if (w_lane != 2'b00) w_error = 1'b1;
            w_wmask     = 32'hFFFF_FFFF;
            w_wbits     = r_wdata;
            w_load_data = w_word;
         end
         default: w_error = 1'b1;
      endcase
   end
`else
   logic w_unused_size;

   assign w_unused_size = ^{req_size, req_signed};
   assign w_error       = w_out_of_range | (w_lane != 2'b00);
   assign w_wmask       = 32'hFFFF_FFFF;
   assign w_wbits       = r_wdata;
   assign w_load_data   = w_word;
`endif

   assign w_mem_we = w_access & r_we & ~w_error;

   // NOTE: the array is never reset; reset only blocks a write that lands on the reset edge.
   always_ff @(posedge clock) begin
      if (!reset && w_mem_we)
         r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wbits & w_wmask);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b0;
      end else if (w_access) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= (w_error | r_we) ? 32'h0 : w_load_data;
         r_rsp_error <= w_error;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;

endmodule
